// File: rtl/dekatron_pulse_driver.sv
// dekatron_pulse_driver: two-phase guide pulse sequencer for one dekatron stage; DEKATRON_SEEK_EN adds seek-to-target
module dekatron_pulse_driver #(
  parameter int PULSE_W   = 4,
  parameter int OVERLAP_W = 2,
  parameter int GAP_W     = 4,
  parameter int READY_TO  = 64,
  parameter int CNT_W     = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Req,
  input  logic             Dir,
  input  logic [CNT_W-1:0] Count,
  input  logic             Seek,
  input  logic [9:0]       Target,
  input  logic             Ready,
  input  logic [9:0]       Cathode,
  output logic             PulseRight_n,
  output logic             PulseLeft_n,
  output logic             Busy,
  output logic             Done,
  output logic             Fault
);
  localparam int M1 = PULSE_W > OVERLAP_W ? PULSE_W : OVERLAP_W;
  localparam int M2 = M1 > GAP_W ? M1 : GAP_W;
  localparam int MX = M2 > READY_TO ? M2 : READY_TO;
  localparam int PW = $clog2(MX + 1);
  localparam int SW = CNT_W > 4 ? CNT_W : 4;
  typedef enum logic [2:0] {IDLE, LEAD, BOTH, TRAIL, GAP, WAIT_RDY, FIN} state_t;
  state_t st, st_nx;
  logic [PW-1:0] ph, ph_nx, len_m1;
  logic [SW-1:0] steps, steps_nx, steps_dec;
  logic dir, dir_nx, fault_nx, last;
`ifdef DEKATRON_SEEK_EN
  logic seek, seek_nx;
  logic [9:0] tgt, tgt_nx;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      seek <= 1'b0;
      tgt  <= '0;
    end else begin
      seek <= seek_nx;
      tgt  <= tgt_nx;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{Seek, Target, Cathode};
`endif
  always_comb begin
    len_m1 = (st == LEAD || st == TRAIL) ? PW'(PULSE_W - 1) :
             st == BOTH ? PW'(OVERLAP_W - 1) :
             st == GAP  ? PW'(GAP_W - 1) : PW'(READY_TO - 1);
    last      = ph == len_m1;
    steps_dec = steps - 1'b1;
    st_nx     = st;
    ph_nx     = last ? '0 : ph + 1'b1;
    steps_nx  = steps;
    dir_nx    = dir;
    fault_nx  = Fault;
`ifdef DEKATRON_SEEK_EN
    seek_nx   = seek;
    tgt_nx    = tgt;
`endif
    case (st)
      IDLE: begin
        ph_nx = '0;
        if (Req) begin
          dir_nx   = Dir;
          fault_nx = 1'b0;
          steps_nx = SW'(Count);
          st_nx    = Count == '0 ? FIN : LEAD;
`ifdef DEKATRON_SEEK_EN
          seek_nx  = Seek;
          tgt_nx   = Target;
          if (Seek) begin
            steps_nx = SW'(9);
            fault_nx = !$onehot(Target);
            st_nx    = (!$onehot(Target) || Cathode == Target) ? FIN : LEAD;
          end
`endif
        end
      end
      LEAD:  st_nx = last ? BOTH : LEAD;
      BOTH:  st_nx = last ? TRAIL : BOTH;
      TRAIL: st_nx = last ? GAP : TRAIL;
      GAP:   st_nx = last ? WAIT_RDY : GAP;
      WAIT_RDY: begin
        if (Ready) begin
          ph_nx    = '0;
          steps_nx = steps_dec;
          st_nx    = steps_dec == '0 ? FIN : LEAD;
`ifdef DEKATRON_SEEK_EN
          if (seek) begin
            st_nx    = (Cathode == tgt || steps_dec == '0) ? FIN : LEAD;
            fault_nx = Cathode != tgt && steps_dec == '0;
          end
`endif
        end else if (last) begin
          fault_nx = 1'b1;
          st_nx    = FIN;
        end
      end
      default: begin
        ph_nx = '0;
        st_nx = IDLE;
      end
    endcase
  end
  // outputs decoded from the next state so every port is a flop
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st           <= IDLE;
      ph           <= '0;
      steps        <= '0;
      dir          <= 1'b0;
      PulseRight_n <= 1'b1;
      PulseLeft_n  <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Fault        <= 1'b0;
    end else begin
      st           <= st_nx;
      ph           <= ph_nx;
      steps        <= steps_nx;
      dir          <= dir_nx;
      PulseRight_n <= !((st_nx == LEAD && !dir_nx) || st_nx == BOTH || (st_nx == TRAIL && dir_nx));
      PulseLeft_n  <= !((st_nx == LEAD && dir_nx) || st_nx == BOTH || (st_nx == TRAIL && !dir_nx));
      Busy         <= st_nx != IDLE;
      Done         <= st_nx == FIN;
      Fault        <= fault_nx;
    end
  end
endmodule

// File: tb/tb_dekatron_pulse_driver.sv
// tb_dekatron_pulse_driver: randomized commands checked against a cycle-list model of the pulse train
module tb_dekatron_pulse_driver;
  logic Clk = 0, Rst = 1, Req = 0, Dir = 0, Seek = 0, Ready = 0;
  logic [3:0] Count = 0;
  logic [9:0] Target = 0, Cathode = 10'h001;
  logic PulseRight_n, PulseLeft_n, Busy, Done, Fault;
  int checks = 0, errors = 0, da;
  bit mflt = 0;
  typedef struct packed {logic rdy, pr, pl, busy, done, fault;} exp_t;

  dekatron_pulse_driver dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Dir(Dir), .Count(Count), .Seek(Seek),
    .Target(Target), .Ready(Ready), .Cathode(Cathode), .PulseRight_n(PulseRight_n),
    .PulseLeft_n(PulseLeft_n), .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [4:0] exp);
    checks++;
    assert ({PulseRight_n, PulseLeft_n, Busy, Done, Fault} === exp) else begin
      errors++;
      $error("FAIL %s: got R/L/busy/done/fault=%b want %b", tag,
             {PulseRight_n, PulseLeft_n, Busy, Done, Fault}, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(logic rdy, logic pr, logic pl, logic busy, logic done, logic fault);
    return '{rdy: rdy, pr: pr, pl: pl, busy: busy, done: done, fault: fault};
  endfunction

  // mode 0: Ready tied high, 1: Ready held low, 2: random Ready delay per step
  function automatic logic junk(int mode);
    return mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      Req = 0;
      chk("idle", {1'b1, 1'b1, 1'b0, 1'b0, mflt});
      @(posedge Clk); #1;
    end
  endtask

  task automatic do_cmd(input int cnt, input bit d, input int mode, output int done_at);
    exp_t q[$];
    bit flt = 0;
    int dl, nw;
    for (int s = 0; s < cnt && !flt; s++) begin
      dl = mode == 0 ? 0 : mode == 1 ? 64 :
           ($urandom_range(0, 9) == 0 ? 64 : int'($urandom_range(0, 6)));
      repeat (4) q.push_back(mk(junk(mode), d, !d, 1, 0, 0));
      repeat (2) q.push_back(mk(junk(mode), 0, 0, 1, 0, 0));
      repeat (4) q.push_back(mk(junk(mode), !d, d, 1, 0, 0));
      repeat (4) q.push_back(mk(junk(mode), 1, 1, 1, 0, 0));
      nw = dl < 64 ? dl + 1 : 64;
      for (int j = 0; j < nw; j++) q.push_back(mk(dl < 64 && j == dl, 1, 1, 1, 0, 0));
      flt = dl >= 64;
    end
    q.push_back(mk(junk(mode), 1, 1, 1, 1, flt));
    q.push_back(mk(1'b0, 1, 1, 0, 0, flt));
    @(negedge Clk);
    Req = 1; Dir = d; Count = 4'(cnt);
    Seek = 1'($urandom); Target = 10'($urandom); Cathode = 10'($urandom);
    @(posedge Clk); #1;
    done_at = -1;
    foreach (q[i]) begin
      Req = (i < q.size() - 1) ? 1'($urandom) : 1'b0;
      Dir = 1'($urandom); Count = 4'($urandom);
      Ready = q[i].rdy;
      chk($sformatf("cmd_n%0d_d%0d_cyc%0d", cnt, d, i + 1),
          {q[i].pr, q[i].pl, q[i].busy, q[i].done, q[i].fault});
      if (Done === 1'b1 && done_at < 0) done_at = i + 1;
      @(posedge Clk); #1;
    end
    mflt = flt;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("reset", 5'b11000);
    Rst = 0;
    idle(2);
    do_cmd(3, 0, 0, da);
    chk_int("done_at_n3", da, 46);
    do_cmd(1, 1, 0, da);
    chk_int("done_at_n1_rev", da, 16);
    do_cmd(2, 0, 1, da);
    chk_int("done_at_timeout", da, 79);
    idle(3);
    do_cmd(0, 0, 2, da);
    chk_int("done_at_n0", da, 1);
    idle(1);
    @(negedge Clk);
    Req = 1; Dir = 0; Count = 5;
    @(posedge Clk); #1;
    Req = 0;
    repeat (4) begin
      @(posedge Clk); #1;
    end
    chk("both_phase", 5'b00100);
    Rst = 1;
    @(posedge Clk); #1;
    Rst = 0;
    mflt = 0;
    chk("rst_mid_cmd", 5'b11000);
    idle(4);
    do_cmd(1, 0, 0, da);
    chk_int("done_after_rst", da, 16);
    for (int k = 0; k < 25; k++) begin
      do_cmd($urandom_range(0, 15), 1'($urandom), 2, da);
      idle($urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
